alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_comb.sv | 41 ++++
 rtl/alu.sv | 33 +++
 tb/tb_alu.sv | 132 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and data width for the ALU and its datapath.
package alu_pkg;
    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_NOR   = 4'b0101,
        OP_SLT   = 4'b0110,
        OP_SLTU  = 4'b0111,
        OP_SLL   = 4'b1000,
        OP_SRL   = 4'b1001,
        OP_SRA   = 4'b1010,
        OP_PASSA = 4'b1011,
        OP_PASSB = 4'b1100,
        OP_ROL   = 4'b1101,
        OP_ROR   = 4'b1110,
        OP_RSVD  = 4'b1111
    } op_t;
endpackage

// File: rtl/alu_comb.sv
// Combinational ALU datapath: f(A, B, Opin), zero latency, no flow control.
module alu_comb
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [3:0]        Opin,
    output logic [DATA_W-1:0] f
);
    logic [4:0]            shamt;
    logic [2*DATA_W-1:0]   rol_full;
    logic [2*DATA_W-1:0]   ror_full;

    assign shamt = B[4:0];

    // Rotates via a doubled operand so an amount of 0 needs no special case.
    assign rol_full = {A, A} << shamt;
    assign ror_full = {A, A} >> shamt;

    always_comb begin
        f = '0;
        case (op_t'(Opin))
            OP_ADD:   f = A + B;
            OP_SUB:   f = A - B;
            OP_AND:   f = A & B;
            OP_OR:    f = A | B;
            OP_XOR:   f = A ^ B;
            OP_NOR:   f = ~(A | B);
            OP_SLT:   f = {31'd0, ($signed(A) < $signed(B))};
            OP_SLTU:  f = {31'd0, (A < B)};
            OP_SLL:   f = A << shamt;
            OP_SRL:   f = A >> shamt;
            OP_SRA:   f = $unsigned($signed(A) >>> shamt);
            OP_PASSA: f = A;
            OP_PASSB: f = B;
            OP_ROL:   f = rol_full[2*DATA_W-1:DATA_W];
            OP_ROR:   f = ror_full[DATA_W-1:0];
            default:  f = '0;
        endcase
    end
endmodule

// File: rtl/alu.sv
// Registered 32-bit ALU: 1-cycle latency, one op per cycle, always ready (no backpressure).
// Synchronous reset forces result to 0 and zero to 1.
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [3:0]        Opin,
    output logic [DATA_W-1:0] result,
    output logic              zero
);
    logic [DATA_W-1:0] f;

    alu_comb u_comb (
        .A    (A),
        .B    (B),
        .Opin (Opin),
        .f    (f)
    );

    // zero is derived from f, not the register, so both load on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            zero   <= 1'b1;
        end else begin
            result <= f;
            zero   <= (f == '0);
        end
    end
endmodule

// File: tb/tb_alu.sv
// Directed vector bench for the registered ALU, plus reset and input-hold sequences.
module tb_alu;
    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  Opin;
    logic [31:0] result;
    logic        zero;

    int applied;
    int miscompares;

    alu dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .Opin   (Opin),
        .result (result),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] exp_res);
        logic exp_zero;
        exp_zero = (exp_res == 32'h0);
        applied++;
        if (result !== exp_res || zero !== exp_zero) begin
            miscompares++;
            $display("FAIL %s: got result=%h zero=%b, expected result=%h zero=%b",
                     name, result, zero, exp_res, exp_zero);
        end
    endtask

    task automatic add_vec(input string n, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e);
        vec_t v;
        v.name = n; v.op = op; v.a = a; v.b = b; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        applied     = 0;
        miscompares = 0;

        add_vec("add_1b_2e",   4'b0000, 32'h1B,       32'h2E,       32'h49);
        add_vec("nor_1b_2e",   4'b0101, 32'h1B,       32'h2E,       32'hFFFFFFC0);
        add_vec("sltu_1b_2e",  4'b0111, 32'h1B,       32'h2E,       32'h1);
        add_vec("sra_1b_2e",   4'b1010, 32'h1B,       32'h2E,       32'h0);
        add_vec("sll_1b_2e",   4'b1000, 32'h1B,       32'h2E,       32'h0006C000);
        add_vec("sub_eq",      4'b0001, 32'h5,        32'h5,        32'h0);
        add_vec("sub_borrow",  4'b0001, 32'h0,        32'h1,        32'hFFFFFFFF);
        add_vec("slt_neg",     4'b0110, 32'hFFFFFFFF, 32'h1,        32'h1);
        add_vec("sltu_big",    4'b0111, 32'hFFFFFFFF, 32'h1,        32'h0);
        add_vec("sra_31",      4'b1010, 32'h80000000, 32'd31,       32'hFFFFFFFF);
        add_vec("rsvd",        4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h0);
        add_vec("rol_1",       4'b1101, 32'h80000001, 32'h1,        32'h00000003);
        add_vec("add_carry",   4'b0000, 32'hFFFFFFFF, 32'h1,        32'h0);
        add_vec("and",         4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
        add_vec("or",          4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0);
        add_vec("xor",         4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);
        add_vec("srl_31",      4'b1001, 32'h80000000, 32'd31,       32'h1);
        add_vec("srl_hi_ign",  4'b1001, 32'hF0000000, 32'h24,       32'h0F000000);
        add_vec("sll_31",      4'b1000, 32'h1,        32'd31,       32'h80000000);
        add_vec("passa",       4'b1011, 32'hDEADBEEF, 32'h11111111, 32'hDEADBEEF);
        add_vec("passb",       4'b1100, 32'h22222222, 32'hCAFEF00D, 32'hCAFEF00D);
        add_vec("ror_1",       4'b1110, 32'h00000003, 32'h1,        32'h80000001);
        add_vec("rol_0",       4'b1101, 32'h12345678, 32'h0,        32'h12345678);
        add_vec("ror_0_hi",    4'b1110, 32'h12345678, 32'h20,       32'h12345678);
        add_vec("rol_4",       4'b1101, 32'h12345678, 32'h4,        32'h23456781);
        add_vec("ror_4",       4'b1110, 32'h12345678, 32'h4,        32'h81234567);
        add_vec("slt_pos_neg", 4'b0110, 32'h1,        32'hFFFFFFFF, 32'h0);
        add_vec("slt_min_max", 4'b0110, 32'h80000000, 32'h7FFFFFFF, 32'h1);
        add_vec("sra_pos_31",  4'b1010, 32'h7FFFFFFF, 32'd31,       32'h0);
        add_vec("sra_0",       4'b1010, 32'h80000000, 32'h0,        32'h80000000);
        add_vec("sll_0",       4'b1000, 32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5);

        // Reset with a non-zero computation pending: reset must win.
        reset = 1'b1; Opin = 4'b0000; A = 32'h7; B = 32'h8;
        @(posedge clk); @(posedge clk); #1;
        check("reset_state", 32'h0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            Opin = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
            @(posedge clk); #1;
            check(vecs[i].name, vecs[i].exp);
            @(negedge clk);
        end

        // Mid-stream reset, then the first post-reset result.
        Opin = 4'b0000; A = 32'h1; B = 32'h1; reset = 1'b1;
        @(posedge clk); #1;
        check("midreset_hold", 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_reset_add", 32'h2);

        // Input changes between edges must not reach the outputs.
        @(negedge clk);
        Opin = 4'b1011; A = 32'h0BADF00D; B = 32'h0;
        #2;
        check("hold_between_edges", 32'h2);
        @(posedge clk); #1;
        check("hold_then_load", 32'h0BADF00D);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion, expected finish before 100000");
        $fatal(1);
    end
endmodule
